// File: rtl/arb_rr.sv
// Round-robin arbiter with registered one-hot grant and a hold limit that
// forces rotation away from a long-running holder when others are waiting.
module arb_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     hold_cnt_q, hold_cnt_d;

  logic [N-1:0]   others;
  logic           keep;
  logic           found;
  logic [IDW-1:0] pick;
  int             idx;

  always_comb begin
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    found         = 1'b0;
    pick          = '0;
    idx           = 0;

    // grant_q is one-hot on the holder, so masking it leaves the waiters.
    others = req & ~grant_q;
    keep   = grant_valid_q && (|(req & grant_q)) &&
             ((MAX_HOLD == 0) || (hold_cnt_q < MAX_HOLD_L) || (others == '0));

    // ptr holds the current holder, so scanning from ptr+1 naturally
    // visits a preempted holder last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end

    if (keep) begin
      if (hold_cnt_q != 8'hFF) hold_cnt_d = hold_cnt_q + 8'd1;
    end else if (found) begin
      grant_d       = N'(1) << pick;
      grant_id_d    = pick;
      grant_valid_d = 1'b1;
      ptr_d         = pick;
      hold_cnt_d    = 8'd1;
    end else begin
      grant_d       = '0;
      grant_id_d    = '0;
      grant_valid_d = 1'b0;
      hold_cnt_d    = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= IDW'(N - 1);
      hold_cnt_q    <= 8'd0;
    end else begin
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule
